// File: rtl/rv_pkg.sv
// Shared RV core definitions: widths, reset PC, NOP/opcode encodings and fetch FSM states.
// FETCH_MISALIGN_TRAP_EN adds the HALT state used by the misaligned-target trap.
package rv_pkg;

  localparam int          RV_XLEN     = 32;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam int          OPC_W       = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'h03;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'h13;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'h17;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'h33;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'h37;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'h67;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'h6F;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN
`ifdef FETCH_MISALIGN_TRAP_EN
    , ST_HALT
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} pairs; flush wins over push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf
  import rv_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wr, r_rd;
  logic [CW-1:0]           r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage needs no reset: the head is only observed while non-empty.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues imem requests, buffers responses for decode.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise o_misaligned and halt fetch.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int               XLEN      = RV_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(RV_RESET_PC),
  parameter int               BUF_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_imem_req,
  output logic [XLEN-1:0]  o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [XLEN-1:0]  i_imem_rdata,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic             o_misaligned,
`endif
  output logic             o_valid,
  output logic [XLEN-1:0]  o_instr,
  output logic [XLEN-1:0]  o_pc,
  output logic [OPC_W-1:0] o_opcode
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, r_rsp_pc, w_tgt;
  logic [CW-1:0]     r_outst, r_stale, w_outst_nxt, w_stale_nxt, w_occ;
  logic              w_gnt, w_drop, w_push, w_pop, w_full, w_empty, w_room;
  logic [2*XLEN-1:0] w_head;

  assign w_tgt  = i_redirect_pc & ~XLEN'(3);
  assign w_room = ((r_outst + w_occ) < CW'(BUF_DEPTH)) && !w_full;
  assign o_imem_req  = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && w_room;
  assign o_imem_addr = r_pc;

  assign w_gnt  = o_imem_req && i_imem_gnt;
  assign w_drop = (r_stale != '0);
  assign w_push = i_imem_rvalid && !w_drop && !i_redirect;
  assign w_pop  = o_valid && !i_stall && !i_redirect;

  // On redirect everything still in flight after this cycle becomes stale.
  assign w_outst_nxt = r_outst + CW'(w_gnt) - CW'(i_imem_rvalid);
  assign w_stale_nxt = i_redirect ? w_outst_nxt
                                  : r_stale - CW'(i_imem_rvalid && w_drop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_RUN;
      ST_DRAIN: if (w_stale_nxt == '0) w_state_nxt = ST_RUN;
      default:  ;
    endcase
    if (i_redirect) begin
      w_state_nxt = (w_stale_nxt != '0) ? ST_DRAIN : ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (i_redirect_pc[1:0] != 2'b00) w_state_nxt = ST_HALT;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outst  <= '0;
      r_stale  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_outst <= w_outst_nxt;
      r_stale <= w_stale_nxt;
      if (i_redirect) begin
        r_pc     <= w_tgt;
        r_rsp_pc <= w_tgt;
      end else begin
        if (w_gnt)  r_pc     <= r_pc + XLEN'(4);
        if (w_push) r_rsp_pc <= r_rsp_pc + XLEN'(4);
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        o_misaligned <= 1'b0;
    else if (i_redirect) o_misaligned <= (i_redirect_pc[1:0] != 2'b00);
  end
`endif

  fetch_buf #(.W(2*XLEN), .DEPTH(BUF_DEPTH)) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_data  ({r_rsp_pc, i_imem_rdata}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occ)
  );

  assign o_valid  = !w_empty;
  assign o_instr  = w_empty ? XLEN'(RV_NOP) : w_head[XLEN-1:0];
  assign o_pc     = w_empty ? RESET_PC      : w_head[2*XLEN-1:XLEN];
  assign o_opcode = o_instr[OPC_W-1:0];

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, issues word requests to instruction memory, and buffers returned instructions.
- Presents instructions in order to the decode stage; `o_opcode` drives the main control decoder's opcode input directly.
- Handles pipeline stall from the hazard logic and redirect (branch/jump) from execute, including discard of stale in-flight responses.

Parameters:
- XLEN, 32, PC/instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries; also maximum outstanding requests (power of two, ≥2).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  XLEN  fetch word address.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  response data valid (in order, ≥1 cycle after gnt).
- i_imem_rdata  in  XLEN  response instruction.
- i_stall  in  1  decode cannot accept; hold head.
- i_redirect  in  1  redirect fetch to i_redirect_pc.
- i_redirect_pc  in  XLEN  redirect target.
- o_valid  out  1  o_instr/o_pc valid.
- o_instr  out  XLEN  head instruction.
- o_pc  out  XLEN  PC of head instruction.
- o_opcode  out  7  o_instr[6:0], to main control decoder.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, buffer empty, outstanding=0, stale=0; o_imem_req=0, o_valid=0, o_instr=32'h0000_0013 (NOP), o_pc=RESET_PC, o_opcode=7'h13.
- FSM states:
  - BOOT: one cycle after reset release → RUN.
  - RUN: normal fetching.
  - DRAIN: stale>0 after redirect; returns to RUN when stale reaches 0.
- Request rule: o_imem_req=1 in RUN/DRAIN when outstanding + occupancy < BUF_DEPTH. Address is stable while req && !gnt, except on redirect.
- On gnt: pc += 4 (wraps modulo 2^XLEN); outstanding++.
- On rvalid: outstanding--. If stale>0, the response is dropped and stale--. Otherwise it is written to the buffer tail with its PC. Occupancy can never overflow by construction.
- Latency: rvalid at cycle N → o_valid=1 at N+1 (registered buffer, no bypass).
- Consume: head pops when o_valid && !i_stall. Pop and write in the same cycle are both allowed.
- Redirect (highest priority, overrides i_stall):
  - Buffer flushed, o_valid=0 next cycle.
  - pc = i_redirect_pc.
  - stale = outstanding, plus 1 if gnt in the same cycle, minus 1 if rvalid in the same cycle.
  - An ungranted pending request is re-addressed to the new pc next cycle.
- Redirect while DRAIN: stale is recomputed as above; already-stale responses remain stale.
- Target alignment: bits [1:0] of i_redirect_pc are forced to 0.
- Buffer full: no new requests; in-flight responses always fit.
- o_opcode is purely combinational from o_instr.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output o_misaligned (1 bit, reset 0) and state HALT.
  - A redirect with i_redirect_pc[1:0]≠0 sets o_misaligned=1 and enters HALT: no requests are issued, stale responses are still drained and dropped, o_valid stays 0.
  - The next aligned redirect clears o_misaligned and resumes.
- Disabled: low bits are silently cleared, and there is no port or state.

Decomposition:
- Shared package (rv_pkg): XLEN, RESET_PC default, NOP encoding 32'h13, opcode width 7.
  - Opcode constants move here from the global defines.
- Fetch FSM state enum lives in the same package.
- One sub-module: fetch_buf, a BUF_DEPTH-entry synchronous FIFO of {pc, instr} with push/pop/flush, full/empty, and an occupancy count.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt → addresses 0x0, 0x4, 0x8; o_valid first high 3 cycles after reset release with o_pc=0x0; o_opcode=rdata[6:0].
- i_stall held 5 cycles with data returning → at most BUF_DEPTH=2 outstanding plus buffered, o_imem_req drops, head o_pc unchanged; release → in-order PCs, no loss or duplication.
- Redirect to 0x100 with 2 requests outstanding → both responses dropped, next o_valid shows o_pc=0x100 with its rdata.
- Redirect in the same cycle as gnt and rvalid → stale=outstanding (count before that cycle); no stale instruction appears.
- gnt held low 4 cycles, then redirect → o_imem_addr changes to the target next cycle, and pc wraps correctly from 0xFFFF_FFFC to 0x0.
- FETCH_MISALIGN_TRAP_EN: redirect to 0x102 → o_misaligned=1, no requests, o_valid=0. Redirect to 0x200 → o_misaligned=0, fetch resumes at 0x200. Without the macro: fetch resumes at 0x100.
